// File: rtl/iq_pair_sequencer.sv
// Sweeps an external IQ pair mux and presents each pair on a valid/ready port.
// Define IQ_PAIR_SEQ_LOOP_EN to add the loop input (continuous re-sweep).
module iq_pair_sequencer #(
  parameter int SIZE     = 8,
  parameter int NB_PAIRS = 5
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic            abort,
`ifdef IQ_PAIR_SEQ_LOOP_EN
  input  logic            loop,
`endif
  output logic [2:0]      sel,
  input  logic [SIZE-1:0] mux_out1,
  input  logic [SIZE-1:0] mux_out2,
  output logic [SIZE-1:0] pair_i,
  output logic [SIZE-1:0] pair_q,
  output logic [2:0]      pair_idx,
  output logic            pair_valid,
  input  logic            pair_ready,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    PRESENT,
    DONE
  } state_e;

  localparam logic [2:0] LAST = 3'(NB_PAIRS - 1);
  localparam logic [2:0] PARK = 3'd7;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      sel_q;
  logic [SIZE-1:0] pi_q, pq_q;
  logic [2:0]      pidx_q;
  logic            valid_q, busy_q;
  logic            done_q, ovr_q;
  logic [1:0]      rsync_q;
  logic            rst_n;
  logic            loop_en;

`ifdef IQ_PAIR_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  // Assert asynchronously, release on the second clock edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsync_q <= 2'b00;
    end else begin
      rsync_q <= {rsync_q[0], 1'b1};
    end
  end

  assign rst_n = rsync_q[1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (abort) begin
      state_d = IDLE;
      idx_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SELECT;
            idx_d   = 3'd0;
          end
        end
        SELECT: state_d = PRESENT;
        PRESENT: begin
          if (pair_ready) begin
            if (idx_q == LAST) begin
              state_d = DONE;
            end else begin
              state_d = SELECT;
              idx_d   = idx_q + 3'd1;
            end
          end
        end
        DONE: begin
          if (loop_en) begin
            state_d = SELECT;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      sel_q   <= PARK;
      pi_q    <= '0;
      pq_q    <= '0;
      pidx_q  <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= (state_d == SELECT || state_d == PRESENT)
                 ? idx_d : PARK;
      valid_q <= (state_d == PRESENT);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      ovr_q   <= start & busy_q;
      if (state_q == SELECT) begin
        pi_q   <= mux_out1;
        pq_q   <= mux_out2;
        pidx_q <= idx_q;
      end
    end
  end

  assign sel        = sel_q;
  assign pair_i     = pi_q;
  assign pair_q     = pq_q;
  assign pair_idx   = pidx_q;
  assign pair_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_iq_pair_sequencer.sv
// Bench for iq_pair_sequencer: directed timing scenarios plus random sweeps
// checked against a transaction queue of expected pairs.
module tb_iq_pair_sequencer;

  localparam int SIZE = 8;
  localparam int NB   = 5;

  typedef struct packed {
    logic [2:0]      idx;
    logic [SIZE-1:0] i;
    logic [SIZE-1:0] q;
  } pair_t;

  logic            clk = 1'b0;
  logic            nrst, start, abort, pair_ready;
  logic            loop;
  logic [2:0]      sel;
  logic [SIZE-1:0] mux_out1, mux_out2;
  logic [SIZE-1:0] pair_i, pair_q;
  logic [2:0]      pair_idx;
  logic            pair_valid, busy, done, overrun;
  logic [SIZE-1:0] tbl1 [NB];
  logic [SIZE-1:0] tbl2 [NB];
  pair_t           expq [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iq_pair_sequencer #(.SIZE(SIZE), .NB_PAIRS(NB)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .abort      (abort),
`ifdef IQ_PAIR_SEQ_LOOP_EN
    .loop       (loop),
`endif
    .sel        (sel),
    .mux_out1   (mux_out1),
    .mux_out2   (mux_out2),
    .pair_i     (pair_i),
    .pair_q     (pair_q),
    .pair_idx   (pair_idx),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  // Mux model: parked (sel out of range) drives zero.
  always_comb begin
    mux_out1 = '0;
    mux_out2 = '0;
    if (int'(sel) < NB) begin
      mux_out1 = tbl1[int'(sel)];
      mux_out2 = tbl2[int'(sel)];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_table();
    for (int k = 0; k < NB; k++) begin
      tbl1[k] = SIZE'(2 * k + 1);
      tbl2[k] = SIZE'(2 * k + 2);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pair_ready = 1'b0;
    loop = 1'b0;
    ramp_table();
    #2 nrst = 1'b0;
    tick();
    tick();
    checks++;
    if (sel !== 3'd7) begin
      errors++;
      $display("FAIL reset_sel got %0d exp 7", sel);
    end
    checks++;
    if ({pair_i, pair_q, pair_idx} !== '0) begin
      errors++;
      $display("FAIL reset_pair got %0h/%0h/%0d exp 0",
               pair_i, pair_q, pair_idx);
    end
    checks++;
    if ({pair_valid, busy, done, overrun} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
               {pair_valid, busy, done, overrun});
    end
    nrst = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || sel !== 3'd7) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b sel=%0d exp 0/7",
               busy, sel);
    end
  endtask

  task automatic test_sweep();
    int ev, es;
    ramp_table();
    pair_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = 1'b0;
      ev = (c % 2 == 0 && c >= 2 && c <= 10) ? 1 : 0;
      es = (c >= 1 && c <= 10) ? (c - 1) / 2 : 7;
      checks++;
      if (pair_valid !== 1'(ev)) begin
        errors++;
        $display("FAIL sweep_valid c=%0d got %b exp %0d",
                 c, pair_valid, ev);
      end
      checks++;
      if (sel !== 3'(es)) begin
        errors++;
        $display("FAIL sweep_sel c=%0d got %0d exp %0d", c, sel, es);
      end
      checks++;
      if (busy !== 1'(c <= 11) || done !== 1'(c == 11)) begin
        errors++;
        $display("FAIL sweep_busy_done c=%0d got %b%b", c, busy, done);
      end
      if (ev == 1) begin
        checks++;
        if (pair_i !== SIZE'(c - 1) || pair_q !== SIZE'(c)
            || pair_idx !== 3'((c - 2) / 2)) begin
          errors++;
          $display("FAIL sweep_pair c=%0d got %0d,%0d,%0d exp %0d,%0d,%0d",
                   c, pair_i, pair_q, pair_idx, c - 1, c, (c - 2) / 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    ramp_table();
    pair_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 1'b0;
      pair_ready = !(c >= 6 && c <= 9);
      if (c >= 6 && c <= 10) begin
        checks++;
        if (pair_valid !== 1'b1 || pair_i !== 8'd5
            || pair_q !== 8'd6 || pair_idx !== 3'd2) begin
          errors++;
          $display("FAIL stall_hold c=%0d got %b %0d,%0d,%0d exp 1 5,6,2",
                   c, pair_valid, pair_i, pair_q, pair_idx);
        end
      end
      if (c == 12) begin
        checks++;
        if (pair_valid !== 1'b1 || pair_idx !== 3'd3 || pair_i !== 8'd7) begin
          errors++;
          $display("FAIL stall_resume got %b idx=%0d i=%0d exp 1 3 7",
                   pair_valid, pair_idx, pair_i);
        end
      end
      if (c == 15) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL stall_done got %b exp 1", done);
        end
      end
    end
  endtask

  task automatic test_overrun();
    ramp_table();
    pair_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = (c == 3 || c == 11);
      checks++;
      if (overrun !== 1'(c == 4 || c == 12)) begin
        errors++;
        $display("FAIL overrun_pulse c=%0d got %b", c, overrun);
      end
      if (c == 8) begin
        checks++;
        if (pair_valid !== 1'b1 || pair_idx !== 3'd3) begin
          errors++;
          $display("FAIL overrun_sweep got %b idx=%0d exp 1 3",
                   pair_valid, pair_idx);
        end
      end
      if (c == 11) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL overrun_done got %b exp 1", done);
        end
      end
      if (c >= 12) begin
        checks++;
        if (busy !== 1'b0 || pair_valid !== 1'b0 || sel !== 3'd7) begin
          errors++;
          $display("FAIL done_start_ignored c=%0d got busy=%b v=%b sel=%0d",
                   c, busy, pair_valid, sel);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    ramp_table();
    pair_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      abort = (c == 8);
      if (c == 8) begin
        checks++;
        if (pair_valid !== 1'b1 || pair_idx !== 3'd3) begin
          errors++;
          $display("FAIL abort_pre got %b idx=%0d exp 1 3",
                   pair_valid, pair_idx);
        end
      end
      if (c >= 9) begin
        checks++;
        if (pair_valid !== 1'b0 || busy !== 1'b0
            || done !== 1'b0 || sel !== 3'd7) begin
          errors++;
          $display("FAIL abort_idle c=%0d got v=%b b=%b d=%b sel=%0d",
                   c, pair_valid, busy, done, sel);
        end
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    ramp_table();
    pair_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
    end
    pair_ready = 1'b0;
    checks++;
    if (pair_valid !== 1'b1 || pair_idx !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_pre got %b idx=%0d exp 1 1",
               pair_valid, pair_idx);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (sel !== 3'd7 || {pair_i, pair_q, pair_idx} !== '0
        || {pair_valid, busy, done, overrun} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_async got sel=%0d v=%b b=%b d=%b i=%0d",
               sel, pair_valid, busy, done, pair_i);
    end
    tick();
    nrst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nodone got d=%b b=%b exp 0 0", done, busy);
      end
    end
  endtask

  task automatic test_random();
    pair_t p, held;
    logic  hold, last_hs, after_done, finished, exp_ovr;
    for (int s = 0; s < 20; s++) begin
      for (int k = 0; k < NB; k++) begin
        tbl1[k] = SIZE'($urandom);
        tbl2[k] = SIZE'($urandom);
        p.idx = 3'(k);
        p.i = tbl1[k];
        p.q = tbl2[k];
        expq.push_back(p);
      end
      start = 1'b1;
      pair_ready = 1'b0;
      hold = 1'b0;
      last_hs = 1'b0;
      after_done = 1'b0;
      finished = 1'b0;
      exp_ovr = 1'b0;
      held = '0;
      for (int c = 1; c <= 200 && !finished; c++) begin
        tick();
        checks++;
        if (overrun !== exp_ovr) begin
          errors++;
          $display("FAIL rnd_overrun s=%0d c=%0d got %b exp %b",
                   s, c, overrun, exp_ovr);
        end
        if (c <= 2) begin
          checks++;
          if (pair_valid !== 1'(c == 2) || sel !== 3'd0) begin
            errors++;
            $display("FAIL rnd_latency s=%0d c=%0d got v=%b sel=%0d",
                     s, c, pair_valid, sel);
          end
        end
        if (last_hs) begin
          checks++;
          if (done !== 1'b1 || busy !== 1'b1 || pair_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_done s=%0d got d=%b b=%b v=%b exp 1 1 0",
                     s, done, busy, pair_valid);
          end
          last_hs = 1'b0;
          after_done = 1'b1;
        end else if (after_done) begin
          checks++;
          if (done !== 1'b0 || busy !== 1'b0 || sel !== 3'd7) begin
            errors++;
            $display("FAIL rnd_end s=%0d got d=%b b=%b sel=%0d",
                     s, done, busy, sel);
          end
          finished = 1'b1;
        end else begin
          checks++;
          if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rnd_busy s=%0d c=%0d got d=%b b=%b exp 0 1",
                     s, c, done, busy);
          end
        end
        if (hold) begin
          checks++;
          if (pair_valid !== 1'b1 || {pair_idx, pair_i, pair_q} !== held) begin
            errors++;
            $display("FAIL rnd_stable s=%0d got %0d,%0h,%0h exp %0h",
                     s, pair_idx, pair_i, pair_q, held);
          end
        end
        if (pair_valid === 1'b1) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL rnd_extra s=%0d got idx=%0d exp none",
                     s, pair_idx);
          end else if ({pair_idx, pair_i, pair_q} !== expq[0]
                       || sel !== pair_idx) begin
            errors++;
            $display("FAIL rnd_pair s=%0d got %0d,%0h,%0h sel=%0d exp %0h",
                     s, pair_idx, pair_i, pair_q, sel, expq[0]);
          end
        end
        start = !finished && ($urandom_range(0, 7) == 0);
        exp_ovr = start;
        pair_ready = 1'($urandom_range(0, 1));
        hold = pair_valid && !pair_ready;
        held = {pair_idx, pair_i, pair_q};
        if (pair_valid === 1'b1 && pair_ready && expq.size() > 0) begin
          void'(expq.pop_front());
          if (expq.size() == 0) last_hs = 1'b1;
        end
      end
      if (!finished) begin
        checks++;
        errors++;
        $display("FAIL rnd_timeout s=%0d got busy=%b exp sweep end", s, busy);
      end
      start = 1'b0;
      pair_ready = 1'b0;
      expq.delete();
      tick();
      tick();
    end
  endtask

`ifdef IQ_PAIR_SEQ_LOOP_EN
  task automatic test_loop();
    ramp_table();
    loop = 1'b1;
    pair_ready = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = 1'b0;
      if (c == 11) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL loop_done got d=%b b=%b exp 1 1", done, busy);
        end
      end
      if (c == 12) begin
        checks++;
        if (sel !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL loop_restart got sel=%0d b=%b d=%b exp 0 1 0",
                   sel, busy, done);
        end
        loop = 1'b0;
      end
      if (c == 13) begin
        checks++;
        if (pair_valid !== 1'b1 || pair_idx !== 3'd0 || pair_i !== 8'd1) begin
          errors++;
          $display("FAIL loop_pair got v=%b idx=%0d i=%0d exp 1 0 1",
                   pair_valid, pair_idx, pair_i);
        end
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    tick();
    test_stall();
    tick();
    test_overrun();
    tick();
    test_abort();
    tick();
    test_reset_mid();
    test_random();
`ifdef IQ_PAIR_SEQ_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
